// File: rtl/ysyx_24100006_pkg.sv
// Shared types and constants for the ysyx_24100006 fetch path.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: fetch FSM state enum, default reset PC, perf counter width,
// and an alignment helper used when choosing the next fetch target.
package ysyx_24100006_pkg;

  // 3-bit encoding; the two unused codes recover to IDLE.
  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_RESP  = 3'd2,
    FETCH_OUT   = 3'd3,
    FETCH_WAIT  = 3'd4,
    FETCH_FAULT = 3'd5
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          PERF_CNT_W       = 32;

  // Instructions are word aligned; any low-order bit set is a fault.
  function automatic logic addr_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24100006_fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, instruction memory and IDU.
// Latency: none (wires only).
// Backpressure: imem request/response and instruction hand-off are valid/ready.
// Ports: master = fetch controller side, slave = memory/IDU side.
interface ysyx_24100006_fetch_ctrl_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rdata;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;

  modport master (
    output imem_req_valid, imem_addr, imem_rsp_ready, inst_valid, instruction,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, imem_rsp_err, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, imem_rsp_ready, inst_valid, instruction,
    output imem_req_ready, imem_rsp_valid, imem_rdata, imem_rsp_err, inst_ready
  );

endinterface

// File: rtl/ysyx_24100006_perf_cnt.sv
// Enable-increment event counter, wraps at 2^W.
// Latency: count visible the cycle after en is sampled high.
// Backpressure: none; counts every enabled cycle.
// Ports: clk, reset (sync active-low), en, cnt.
module ysyx_24100006_perf_cnt
  import ysyx_24100006_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ysyx_24100006_fetch_ctrl.sv
// Multi-cycle fetch sequencer: owns the PC, fetches one word per instruction, hands it to the IDU.
// Latency: response -> inst_valid next cycle; best case 4 cycles per instruction.
// Backpressure: holds imem_req_valid/addr until accepted, holds inst_valid/instruction until inst_ready.
// Ports: clk, reset (sync active-low); npc/npc_valid from the commit path;
//        bus (master) carries the imem request/response and IDU hand-off;
//        pc_F, fault, fault_pc, fetch_count are status outputs.
module ysyx_24100006_fetch_ctrl
  import ysyx_24100006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                npc,
  input  logic                       npc_valid,
  ysyx_24100006_fetch_ctrl_if.master bus,
  output logic [31:0]                pc_F,
  output logic                       fault,
  output logic [31:0]                fault_pc,
  output logic [31:0]                fetch_count
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] fault_pc_q;
  logic [31:0] npc_q;
  logic        pend_q;

  logic [31:0] target;
  logic        target_vld;
  logic        target_bad;
  logic        rsp_fire;
  logic        inst_fire;
  logic        early_npc;
  logic        wait_take;

  // A live npc pulse beats a stored one: it is the more recent retirement.
  assign target     = npc_valid ? npc : npc_q;
  assign target_vld = npc_valid | pend_q;
  assign target_bad = addr_misaligned(target[1:0]);

  assign rsp_fire  = (state_q == FETCH_RESP) && bus.imem_rsp_valid;
  assign inst_fire = (state_q == FETCH_OUT)  && bus.inst_ready;
  assign wait_take = (state_q == FETCH_WAIT) && target_vld;

  // npc can retire before this fetch is consumed; park it for WAIT.
  assign early_npc = npc_valid &&
                     ((state_q == FETCH_REQ) || (state_q == FETCH_RESP) ||
                      (state_q == FETCH_OUT));

  // Moore handshake outputs.
  assign bus.imem_req_valid = (state_q == FETCH_REQ);
  assign bus.imem_rsp_ready = (state_q == FETCH_RESP);
  assign bus.inst_valid     = (state_q == FETCH_OUT);
  assign bus.imem_addr      = pc_q;
  assign bus.instruction    = instr_q;

  assign pc_F     = pc_q;
  assign fault    = (state_q == FETCH_FAULT);
  assign fault_pc = fault_pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (bus.imem_req_ready) state_d = FETCH_RESP;
      end
      FETCH_RESP: begin
        if (bus.imem_rsp_valid) state_d = bus.imem_rsp_err ? FETCH_FAULT : FETCH_OUT;
      end
      FETCH_OUT: begin
        if (bus.inst_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (target_vld) state_d = target_bad ? FETCH_FAULT : FETCH_REQ;
      end
      FETCH_FAULT: state_d = FETCH_FAULT;
      default:     state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      fault_pc_q <= '0;
      npc_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (rsp_fire) begin
        if (bus.imem_rsp_err) fault_pc_q <= pc_q;
        else                  instr_q    <= bus.imem_rdata;
      end
      if (early_npc) begin
        npc_q  <= npc;
        pend_q <= 1'b1;
      end
      if (wait_take) begin
        if (target_bad) begin
          fault_pc_q <= target;
        end else begin
          pc_q   <= target;
          pend_q <= 1'b0;
        end
      end
    end
  end

  ysyx_24100006_perf_cnt #(.W(PERF_CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (inst_fire),
    .cnt   (fetch_count)
  );

endmodule

// File: tb/tb_ysyx_24100006_fetch_ctrl.sv
// Bench for ysyx_24100006_fetch_ctrl: directed scenarios plus a randomized run
// where the bench plays memory, IDU and commit path against a transaction model.
module tb_ysyx_24100006_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc = '0;
  logic        npc_valid = 1'b0;
  logic [31:0] pc_F;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int n_chk = 0;
  int n_bad = 0;

  ysyx_24100006_fetch_ctrl_if bus ();

  always #5 clk = ~clk;

  ysyx_24100006_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .npc_valid   (npc_valid),
    .bus         (bus),
    .pc_F        (pc_F),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic idle_inputs;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    npc_valid          = 1'b0;
    npc                = '0;
  endtask

  // Leaves reset released; the DUT is in its first IDLE cycle on return.
  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_req_vld",  32'(bus.imem_req_valid), 0);
    chk("rst_rsp_rdy",  32'(bus.imem_rsp_ready), 0);
    chk("rst_inst_vld", 32'(bus.inst_valid), 0);
    chk("rst_fault",    32'(fault), 0);
    chk("rst_pc",       pc_F, RPC);
    chk("rst_inst",     bus.instruction, 0);
    chk("rst_count",    fetch_count, 0);
    chk("rst_fault_pc", fault_pc, 0);
    reset = 1'b1;
  endtask

  task automatic run_random(input int n_insn);
    logic [31:0] exp_addr = RPC;
    logic [31:0] inflight = '0;
    int  mem_wait = -1;
    int  req_due = 1;
    int  post_delay = 0;
    int  done = 0;
    int  pulses = 0;
    int  budget = 0;
    bit  busy = 0;
    bit  acked = 0;
    bit  out_pend = 0;
    bit  ack_prev = 0;
    bit  ack_now;
    bit  accepted;
    bit  responding;
    do_reset();
    while (done < n_insn && budget < 4000) begin
      tick();
      budget++;
      chk("r_inst_vld", 32'(bus.inst_valid), 32'(out_pend));
      if (out_pend) chk("r_inst_dat", bus.instruction, mem_word(inflight));
      if (ack_prev) chk("r_count", fetch_count, done);
      if (req_due > 0) begin
        req_due--;
        if (req_due == 0) chk("r_req_timing", 32'(bus.imem_req_valid), 1);
      end
      if (busy) chk("r_one_req", 32'(bus.imem_req_valid), 0);
      if (bus.imem_req_valid) chk("r_addr", bus.imem_addr, exp_addr);
      chk("r_fault", 32'(fault), 0);

      ack_prev   = 0;
      ack_now    = 0;
      accepted   = 0;
      responding = 0;
      npc_valid  = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_err   = 1'b0;
      bus.imem_rdata     = $urandom;

      // Memory side.
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        accepted   = 1;
        inflight   = bus.imem_addr;
        mem_wait   = int'($urandom_range(1, 4));
        busy       = 1;
        acked      = 0;
        pulses     = 0;
        post_delay = int'($urandom_range(0, 2));
      end else if (mem_wait > 0) begin
        mem_wait--;
        if (mem_wait == 0) begin
          chk("r_rsp_rdy", 32'(bus.imem_rsp_ready), 1);
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rdata     = mem_word(inflight);
          responding = 1;
          out_pend   = 1;
          mem_wait   = -1;
        end
      end
      // Outside RESP, spurious responses (even errors) must be ignored.
      if (!responding && mem_wait < 0 && $urandom_range(0, 3) == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'($urandom_range(0, 1));
      end

      // IDU side.
      bus.inst_ready = 1'($urandom_range(0, 1));
      if (bus.inst_valid && bus.inst_ready) begin
        ack_now  = 1;
        ack_prev = 1;
        out_pend = 0;
        done++;
      end

      // Commit side: one or more npc pulses per fetch; the last one wins.
      if (busy && !accepted && (!acked || ack_now)) begin
        if ($urandom_range(0, 3) == 0 || (ack_now && pulses == 0 && $urandom_range(0, 1) == 1)) begin
          npc       = $urandom & 32'hFFFF_FFFC;
          npc_valid = 1'b1;
          exp_addr  = npc;
          pulses++;
        end
        if (ack_now && pulses > 0) begin
          busy    = 0;
          req_due = 2;
        end
      end else if (busy && acked) begin
        if (post_delay > 0) begin
          post_delay--;
        end else begin
          npc       = $urandom & 32'hFFFF_FFFC;
          npc_valid = 1'b1;
          exp_addr  = npc;
          pulses++;
          busy    = 0;
          req_due = 1;
        end
      end
      if (ack_now) acked = 1;
    end
    chk("r_done", done, n_insn);
    tick();
    chk("r_final_count", fetch_count, done);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();

    // Basic fetch with zero-wait memory and IDU.
    do_reset();
    tick();
    chk("t1_req_vld", 32'(bus.imem_req_valid), 1);
    chk("t1_addr", bus.imem_addr, RPC);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("t1_rsp_rdy", 32'(bus.imem_rsp_ready), 1);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'h0000_0413;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("t1_inst_vld", 32'(bus.inst_valid), 1);
    chk("t1_inst", bus.instruction, 32'h0000_0413);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("t1_count", fetch_count, 1);
    chk("t1_wait_inst_vld", 32'(bus.inst_valid), 0);

    // npc in WAIT, slow request acceptance, late response.
    npc       = 32'h8000_0004;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    chk("t2_req_vld", 32'(bus.imem_req_valid), 1);
    chk("t2_addr", bus.imem_addr, 32'h8000_0004);
    chk("t2_pc", pc_F, 32'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_vld", 32'(bus.imem_req_valid), 1);
      chk("t2_hold_addr", bus.imem_addr, 32'h8000_0004);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    // Early npc while the response is outstanding.
    npc       = 32'h8000_0010;
    npc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      npc_valid = 1'b0;
      chk("t2_one_req", 32'(bus.imem_req_valid), 0);
      chk("t2_no_inst", 32'(bus.inst_valid), 0);
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'h00a0_0093;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("t2_inst_vld", 32'(bus.inst_valid), 1);
    chk("t2_inst", bus.instruction, 32'h00a0_0093);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_inst", 32'(bus.inst_valid), 1);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("t3_wait_no_req", 32'(bus.imem_req_valid), 0);
    chk("t3_count", fetch_count, 2);
    tick();
    chk("t3_req_vld", 32'(bus.imem_req_valid), 1);
    chk("t3_addr", bus.imem_addr, 32'h8000_0010);

    // Misaligned target in WAIT.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    npc       = 32'h8000_0006;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    chk("t4_fault", 32'(fault), 1);
    chk("t4_fault_pc", fault_pc, 32'h8000_0006);
    chk("t4_pc_kept", pc_F, 32'h8000_0010);
    for (int i = 0; i < 4; i++) begin
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.inst_ready     = 1'b1;
      npc                = 32'h8000_0020;
      npc_valid          = 1'b1;
      tick();
      chk("t4_no_req", 32'(bus.imem_req_valid), 0);
      chk("t4_no_inst", 32'(bus.inst_valid), 0);
      chk("t4_no_rsp_rdy", 32'(bus.imem_rsp_ready), 0);
      chk("t4_sticky", 32'(fault), 1);
      chk("t4_fault_pc_kept", fault_pc, 32'h8000_0006);
    end
    do_reset();
    tick();
    chk("t4_restart_vld", 32'(bus.imem_req_valid), 1);
    chk("t4_restart_addr", bus.imem_addr, RPC);

    // Access fault on the second fetch.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'h0000_0413;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    npc       = 32'h8000_0004;
    npc_valid = 1'b1;
    tick();
    npc_valid          = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    bus.imem_rdata     = 32'hffff_ffff;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    chk("t5_fault", 32'(fault), 1);
    chk("t5_fault_pc", fault_pc, 32'h8000_0004);
    chk("t5_inst_kept", bus.instruction, 32'h0000_0413);
    for (int i = 0; i < 3; i++) begin
      bus.inst_ready = 1'b1;
      tick();
      chk("t5_no_inst", 32'(bus.inst_valid), 0);
      chk("t5_count", fetch_count, 1);
    end

    // Reset during RESP, stale responses afterwards.
    do_reset();
    tick();
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("t6_in_resp", 32'(bus.imem_rsp_ready), 1);
    reset = 1'b0;
    tick();
    chk("t6_idle_req", 32'(bus.imem_req_valid), 0);
    chk("t6_idle_rsp_rdy", 32'(bus.imem_rsp_ready), 0);
    reset              = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'hbad0_bad0;
    tick();
    chk("t6_req_vld", 32'(bus.imem_req_valid), 1);
    chk("t6_addr", bus.imem_addr, RPC);
    chk("t6_inst_zero_a", bus.instruction, 0);
    chk("t6_no_inst_a", 32'(bus.inst_valid), 0);
    tick();
    chk("t6_inst_zero_b", bus.instruction, 0);
    chk("t6_still_req", 32'(bus.imem_req_valid), 1);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("t6_inst_zero_c", bus.instruction, 0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk("t6_inst_vld", 32'(bus.inst_valid), 1);
    chk("t6_inst", bus.instruction, 32'h0000_0013);

    // Randomized traffic against the transaction model.
    run_random(60);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
